// File: rtl/enigma_pkg.sv
// enigma_pkg: state encoding, ASCII range constants and letter helpers for the char sequencer
package enigma_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;
  localparam logic [7:0] UC_A = 8'h41;
  localparam logic [7:0] UC_Z = 8'h5A;
  localparam logic [7:0] LC_A = 8'h61;
  localparam logic [7:0] LC_Z = 8'h7A;
  localparam logic [7:0] CASE_OFS = 8'h20;
  localparam logic [7:0] ERR_BYTE = 8'h3F;
  function automatic logic is_lower(input logic [7:0] b);
    return b >= LC_A && b <= LC_Z;
  endfunction
  function automatic logic is_alpha(input logic [7:0] b);
    return is_lower(b) || (b >= UC_A && b <= UC_Z);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; full/empty come from an occupancy count so pointers simply wrap
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/enigma_char_sequencer.sv
// enigma_char_sequencer: buffers ASCII bytes, sends letters one at a time to a cipher core
// and forwards results (or pass-through bytes) downstream in input order.
module enigma_char_sequencer
  import enigma_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter bit PASS_NONALPHA = 1'b1,
  parameter int TIMEOUT       = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       core_valid,
  output logic [7:0] core_din,
  input  logic       core_done,
  input  logic [7:0] core_dout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state_q, state_d;
  logic [8:0] cur_q, cur_d, head;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, full, empty, pop;
  assign in_ready = reset_n && !full;
  sync_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk, .reset_n, .push(in_valid && in_ready), .din({in_last, in_data}),
    .pop, .dout(head), .full, .empty
  );
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    cnt_d = '0;
    err_d = err_q;
    pop = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop = 1'b1;
        cur_d = {head[8], is_lower(head[7:0]) ? head[7:0] - CASE_OFS : head[7:0]};
        state_d = is_alpha(head[7:0]) ? ISSUE : (PASS_NONALPHA ? EMIT : IDLE);
      end
      ISSUE: state_d = WAIT;
      // core_done wins over a timeout landing on the same cycle
      WAIT: if (core_done) begin
        cur_d[7:0] = core_dout;
        state_d = EMIT;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        cur_d[7:0] = ERR_BYTE;
        err_d = 1'b1;
        state_d = EMIT;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      EMIT: if (out_ready) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cur_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign core_valid = state_q == ISSUE;
  assign core_din = core_valid ? cur_q[7:0] : '0;
  assign out_valid = state_q == EMIT;
  assign out_data = out_valid ? cur_q[7:0] : '0;
  assign out_last = out_valid && cur_q[8];
  assign err = err_q;
endmodule

// File: tb/tb_enigma_char_sequencer.sv
// tb_enigma_char_sequencer: queue-based reference model with a randomized core latency,
// plus directed literal checks for reset, latency, pass/drop, fill, timeout and mid-run reset.
module tb_enigma_char_sequencer;
  localparam int DEPTH = 8;
  localparam int TO = 16;
  logic clk = 0, reset_n = 0;
  logic in_valid = 0, in_ready, in_last = 0;
  logic [7:0] in_data = 0;
  logic core_valid, core_done;
  logic [7:0] core_din, core_dout;
  logic out_valid, out_ready = 1, out_last, err;
  logic [7:0] out_data;
  logic md = 0, force_done = 0;
  logic [7:0] rb = 0;
  logic i0_valid = 0, i0_last = 0, i0_ready, c0_valid, o0_valid, o0_last, e0;
  logic [7:0] i0_data = 0, c0_din, o0_data;
  int total = 0, bad = 0, fix_lat = 0, cd = 0, lat = 0;
  bit rs = 0, to_issued = 0, err_exp = 0;
  typedef struct {logic [7:0] d; logic last; bit alpha; bit issued; bit to; logic [7:0] res;} ent_t;
  ent_t q[$];
  assign core_done = md | force_done;
  assign core_dout = rb;
  always #5 clk = ~clk;
  enigma_char_sequencer #(.FIFO_DEPTH(DEPTH), .PASS_NONALPHA(1'b1), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .core_valid(core_valid), .core_din(core_din), .core_done(core_done),
    .core_dout(core_dout), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .err(err));
  enigma_char_sequencer #(.FIFO_DEPTH(DEPTH), .PASS_NONALPHA(1'b0), .TIMEOUT(TO)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(i0_valid), .in_ready(i0_ready), .in_data(i0_data),
    .in_last(i0_last), .core_valid(c0_valid), .core_din(c0_din), .core_done(1'b0),
    .core_dout(8'h00), .out_valid(o0_valid), .out_ready(1'b1), .out_data(o0_data),
    .out_last(o0_last), .err(e0));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [7:0] d, input logic l);
    ent_t e;
    bit lower;
    lower = d >= 8'h61 && d <= 8'h7A;
    e.alpha = lower || (d >= 8'h41 && d <= 8'h5A);
    e.d = lower ? d - 8'h20 : d;
    e.last = l;
    e.issued = 0;
    e.to = 0;
    e.res = d;
    return e;
  endfunction

  // reference model: core latency model plus per-cycle output checks
  initial forever begin
    @(posedge clk);
    rs = reset_n;
    #1;
    md = (cd == 1);
    if (cd > 0) cd--;
    @(negedge clk);
    if (!reset_n) begin
      q.delete();
      cd = 0;
      md = 0;
      to_issued = 0;
      err_exp = 0;
      if (!rs) begin
        chk("rst_in_ready", in_ready, 0);
        chk("rst_core_valid", core_valid, 0);
        chk("rst_core_din", core_din, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_err", err, 0);
      end
    end else begin
      if (q.size() < DEPTH) chk("in_ready_free", in_ready, 1);
      else if (q.size() > DEPTH) chk("in_ready_full", in_ready, 0);
      if (core_valid) begin
        if (q.size() == 0 || !q[0].alpha || q[0].issued) chk("core_valid_unexpected", 1, 0);
        else begin
          chk("core_din", core_din, q[0].d);
          lat = fix_lat != 0 ? fix_lat : int'($urandom_range(1, 18));
          q[0].issued = 1;
          q[0].to = lat > TO;
          q[0].res = lat > TO ? 8'h3F : q[0].d + 8'd1;
          rb = core_din + 8'd1;
          if (lat > TO) to_issued = 1;
          if (lat <= 18) cd = lat;
        end
      end
      if (out_valid) begin
        if (q.size() == 0) chk("out_valid_unexpected", 1, 0);
        else begin
          if (q[0].alpha && !q[0].issued) chk("out_before_core", 1, 0);
          else begin
            chk("out_data", out_data, q[0].res);
            chk("out_last", out_last, q[0].last);
          end
          if (q[0].to) err_exp = 1;
          if (out_ready) void'(q.pop_front());
        end
      end
      if (err_exp) chk("err_set", err, 1);
      else if (!to_issued) chk("err_clear", err, 0);
      if (in_valid && in_ready) q.push_back(mk(in_data, in_last));
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    int k = 0;
    in_valid = 1;
    in_data = d;
    in_last = l;
    while (!in_ready && k < 500) begin
      step();
      k++;
    end
    if (!in_ready) chk("push_timeout", 0, 1);
    step();
    in_valid = 0;
  endtask

  task automatic wait_out(output int cyc, output int cv);
    cyc = 0;
    cv = 0;
    while (!out_valid && cyc < 200) begin
      if (core_valid) cv++;
      step();
      cyc++;
    end
    if (!out_valid) chk("out_wait_timeout", 0, 1);
  endtask

  initial begin
    int n, cv, cyc, r;
    logic [7:0] d;
    fix_lat = 3;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_in_ready", in_ready, 0);
    chk("hold_core_valid", core_valid, 0);
    chk("hold_out_valid", out_valid, 0);
    chk("hold_out_data", out_data, 0);
    chk("hold_err", err, 0);
    reset_n = 1;
    step();
    chk("rel_in_ready", in_ready, 1);
    chk("rel_err", err, 0);
    push(8'h61, 0);
    step();
    chk("lat_core_valid", core_valid, 1);
    chk("lat_core_din", core_din, 8'h41);
    step();
    chk("core_pulse_once", core_valid, 0);
    wait_out(cyc, cv);
    chk("a_out_data", out_data, 8'h42);
    chk("a_out_last", out_last, 0);
    step();
    push(8'h20, 1);
    wait_out(cyc, cv);
    chk("pass_latency", cyc, 1);
    chk("pass_data", out_data, 8'h20);
    chk("pass_last", out_last, 1);
    chk("pass_no_core", cv, 0);
    step();
    i0_valid = 1;
    i0_data = 8'h20;
    i0_last = 1;
    step();
    i0_valid = 0;
    n = 0;
    cv = 0;
    repeat (20) begin
      if (o0_valid) n++;
      if (c0_valid) cv++;
      step();
    end
    chk("drop_out", n, 0);
    chk("drop_core", cv, 0);
    i0_valid = 1;
    i0_data = 8'h62;
    i0_last = 0;
    step();
    i0_valid = 0;
    step();
    chk("drop_mode_core_valid", c0_valid, 1);
    chk("drop_mode_core_din", c0_din, 8'h42);
    out_ready = 0;
    in_valid = 1;
    in_data = 8'h41;
    in_last = 0;
    n = 0;
    repeat (40) begin
      if (in_ready) n++;
      step();
    end
    in_valid = 0;
    chk("fill_count", n, DEPTH + 1);
    chk("fill_in_ready", in_ready, 0);
    out_ready = 1;
    n = 0;
    repeat (200) begin
      if (out_valid) begin
        n++;
        chk("drain_data", out_data, 8'h42);
      end
      step();
    end
    chk("drain_count", n, DEPTH + 1);
    fix_lat = 99;
    push(8'h5A, 1);
    n = 0;
    while (!core_valid && n < 20) begin
      step();
      n++;
    end
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    chk("timeout_cycles", n, TO + 1);
    chk("timeout_data", out_data, 8'h3F);
    chk("timeout_last", out_last, 1);
    chk("timeout_err", err, 1);
    step();
    fix_lat = 2;
    push(8'h6B, 0);
    wait_out(cyc, cv);
    chk("after_to_data", out_data, 8'h4C);
    chk("err_sticky", err, 1);
    step();
    fix_lat = 0;
    repeat (4000) begin
      r = int'($urandom_range(0, 2));
      d = r == 0 ? 8'h41 + 8'($urandom_range(0, 25)) :
          r == 1 ? 8'h61 + 8'($urandom_range(0, 25)) : 8'($urandom);
      in_valid = $urandom_range(0, 1) == 1;
      in_data = d;
      in_last = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 3) != 0;
      step();
    end
    in_valid = 0;
    out_ready = 1;
    repeat (400) step();
    chk("random_drained", q.size(), 0);
    fix_lat = 99;
    push(8'h43, 0);
    n = 0;
    while (!core_valid && n < 20) begin
      step();
      n++;
    end
    step();
    step();
    reset_n = 0;
    step();
    step();
    reset_n = 1;
    step();
    force_done = 1;
    step();
    force_done = 0;
    n = 0;
    cv = 0;
    cyc = 0;
    repeat (10) begin
      if (out_valid) n++;
      if (core_valid) cv++;
      if (!in_ready) cyc++;
      step();
    end
    chk("late_done_out", n, 0);
    chk("late_done_core", cv, 0);
    chk("late_done_fifo_empty", cyc, 0);
    chk("late_done_err", err, 0);
    fix_lat = 1;
    push(8'h64, 0);
    step();
    chk("post_rst_core_valid", core_valid, 1);
    wait_out(cyc, cv);
    chk("post_rst_data", out_data, 8'h45);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/enigma_char_sequencer.md
ENIGMA_CHAR_SEQUENCER -- requirements
Module: enigma_char_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, input FIFO entries (power of two, >=2).
REQ-002 Parameter PASS_NONALPHA, default 1; 1 = non-letters forwarded unchanged, 0 = non-letters dropped.
REQ-003 Parameter TIMEOUT, default 64, maximum cycles in WAIT before abort.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 in_valid  in  1  upstream byte valid.
REQ-007 in_ready  out  1  upstream may transfer; equals not-FIFO-full.
REQ-008 in_data  in  8  upstream ASCII byte.
REQ-009 in_last  in  1  marks final byte of a message; travels with the byte.
REQ-010 core_valid  out  1  one-cycle request pulse to the cipher core.
REQ-011 core_din  out  8  uppercase ASCII letter sent to the core.
REQ-012 core_done  in  1  core result strobe; sampled only in WAIT.
REQ-013 core_dout  in  8  core result byte, valid when core_done=1.
REQ-014 out_valid  out  1  downstream byte valid; held until accepted.
REQ-015 out_ready  in  1  downstream accepts when out_valid and out_ready both high.
REQ-016 out_data  out  8  output byte.
REQ-017 out_last  out  1  copy of in_last of the originating byte.
REQ-018 err  out  1  sticky core-timeout flag.

Function
REQ-019 A transfer occurs on an edge where in_valid and in_ready are 1; {in_last, in_data} is pushed into the FIFO.
REQ-020 FSM states IDLE, ISSUE, WAIT, EMIT; reset state IDLE.
REQ-021 IDLE: on an edge with FIFO non-empty, pop head into cur register; next state ISSUE if letter (0x41-0x5A or 0x61-0x7A), else EMIT if PASS_NONALPHA=1, else IDLE (byte discarded).
REQ-022 Lowercase 0x61-0x7A is converted to uppercase by subtracting 0x20 at pop; uppercase unchanged.
REQ-023 ISSUE: core_valid=1 and core_din=cur for exactly one cycle; next state WAIT.
REQ-024 WAIT: on core_done=1, cur data <= core_dout, next EMIT; cycle counter increments each WAIT cycle.
REQ-025 WAIT: when counter reaches TIMEOUT without core_done, cur data <= 0x3F, err <= 1, next EMIT.
REQ-026 EMIT: out_valid=1, out_data/out_last from cur, stable until accepted; on acceptance next IDLE.
REQ-027 core_done outside WAIT is ignored; core_valid is never asserted for non-letters.
REQ-028 Latency: byte accepted into empty FIFO at edge E0 with FSM in IDLE is popped at E1; core_valid (letter) or out_valid (pass-through) is high in the cycle after E1.
REQ-029 Output ordering equals input ordering; at most one byte outstanding at the core.
REQ-030 Push while full is impossible (in_ready=0); simultaneous push and pop on a non-full FIFO both take effect, count unchanged.
REQ-031 FIFO pointers wrap modulo FIFO_DEPTH; full and empty distinguished by occupancy count.

Reset
REQ-032 reset_n=0 at an edge: FSM IDLE, FIFO emptied, WAIT counter 0, err 0, cur cleared.
REQ-033 During and after reset: core_valid=0, core_din=0, out_valid=0, out_data=0, out_last=0, in_ready=1 (in_ready=0 while reset_n=0).
REQ-034 Reset mid-operation discards buffered and in-flight bytes; a core_done arriving after reset is ignored.

Structure
REQ-035 Package enigma_pkg holds the FSM state enum, ASCII constants (0x41, 0x5A, 0x61, 0x7A, case offset 0x20) and error byte 0x3F.
REQ-036 The FIFO is a separate sub-module sync_fifo (parameterised width 9, depth FIFO_DEPTH, same clk/reset_n).

Verification
REQ-037 Reset: hold reset_n=0 3 cycles -> all outputs 0; after release in_ready=1, err=0.
REQ-038 Send 0x61 with core model returning din+1 after 3 cycles -> single core_valid pulse with core_din=0x41, then out_data=0x42.
REQ-039 Send 0x20 in_last=1: PASS_NONALPHA=1 -> out_data=0x20, out_last=1, core_valid never high; PASS_NONALPHA=0 -> no output.
REQ-040 out_ready=0, push 0x41 repeatedly -> exactly FIFO_DEPTH+1 (9) bytes accepted, then in_ready=0; raising out_ready drains 9 bytes 0x42 in order.
REQ-041 Core model never asserts core_done, TIMEOUT=16 -> after 16 WAIT cycles out_data=0x3F, err=1 and remains 1 until reset.
REQ-042 Assert reset_n=0 during WAIT, then pulse core_done after release -> out_valid stays 0, FIFO empty, FSM IDLE.
